cache_line_addr_encoder: RTL and testbench

Rebuilds full 32-bit memory addresses from cache-line fields (tag, index, word offset) and sequences one address per word of a line toward main memory over a req/ack handshake. It is the inverse of the cache's address split: the cache controller hands it a line's tag and index on a miss refill or dirty write-back, and it walks all words of that line. It sits between the cache controller FSM and the memory interface.

---
 rtl/cache_line_addr_encoder_pkg.sv | 36 +++
 rtl/cache_line_addr_encoder_if.sv | 43 ++++
 rtl/cache_line_addr_encoder.sv | 74 +++++++
 tb/tb_cache_line_addr_encoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_line_addr_encoder_pkg.sv
// Shared cache address-field constants, FSM state and line address layout.
// Used by both the address encoder and the cache-side address decoder.
package cache_pkg;

  localparam int TAG_W  = 24;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 2;
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam int WORDS  = 1 << OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Field order here defines the address split for both directions
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } line_addr_t;

  function automatic line_addr_t mk_line(
    input logic [TAG_W-1:0] t,
    input logic [IDX_W-1:0] i,
    input logic [OFF_W-1:0] o
  );
    line_addr_t l;
    l.tag    = t;
    l.index  = i;
    l.offset = o;
    return l;
  endfunction

endpackage

// File: rtl/cache_line_addr_encoder_if.sv
// Controller/memory-side bundle for the line address encoder.
// slave = encoder view, master = controller + memory view.
interface cache_line_addr_encoder_if;
  import cache_pkg::*;

  logic              start;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  index;
  logic [OFF_W-1:0]  first_offset;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [OFF_W-1:0]  word_offset;
  logic              busy;
  logic              done;

  modport slave (
    input  start,
    input  tag,
    input  index,
    input  first_offset,
    input  mem_ack,
    output mem_req,
    output mem_addr,
    output word_offset,
    output busy,
    output done
  );

  modport master (
    output start,
    output tag,
    output index,
    output first_offset,
    output mem_ack,
    input  mem_req,
    input  mem_addr,
    input  word_offset,
    input  busy,
    input  done
  );

endinterface

// File: rtl/cache_line_addr_encoder.sv
// Walks every word address of a cache line toward memory over req/ack.
// Define CACHE_CWF_EN for critical-word-first start offset.
module cache_line_addr_encoder
  import cache_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  cache_line_addr_encoder_if.slave bus
);

  localparam logic [OFF_W:0] LAST_CNT = (OFF_W+1)'(WORDS - 1);

  state_t            r_state;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [OFF_W-1:0]  r_off;
  logic [OFF_W:0]    r_cnt;

  logic [OFF_W-1:0]  w_start_off;
  line_addr_t        w_line;

`ifdef CACHE_CWF_EN
  assign w_start_off = bus.first_offset;
`else
  logic w_unused_foff;
  assign w_unused_foff = ^bus.first_offset;
  assign w_start_off   = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tag   <= '0;
      r_idx   <= '0;
      r_off   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_tag   <= bus.tag;
            r_idx   <= bus.index;
            r_off   <= w_start_off;
            r_cnt   <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            r_off <= r_off + OFF_W'(1);
            r_cnt <= r_cnt + (OFF_W+1)'(1);
            if (r_cnt == LAST_CNT)
              r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_line = mk_line(r_tag, r_idx, r_off);

  assign bus.mem_req     = (r_state == REQ);
  assign bus.busy        = (r_state == REQ);
  assign bus.done        = (r_state == DONE);
  assign bus.mem_addr    = w_line;
  assign bus.word_offset = r_off;

endmodule

// File: tb/tb_cache_line_addr_encoder.sv
// Scoreboard bench: driver queues expected word addresses per line,
// monitor pops and compares on every accepted req/ack.
module tb_cache_line_addr_encoder;
  import cache_pkg::*;

  logic clk;
  logic rst_n;

  cache_line_addr_encoder_if bus();

  cache_line_addr_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          last;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ack_mode = 0;
  int cyc_ctr  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: address = tag * 2^(IDX_W+OFF_W) + index * WORDS + word
  function automatic logic [31:0] ref_addr(input int unsigned t,
                                           input int unsigned i,
                                           input int unsigned w);
    longint unsigned a;
    a = longint'(t) * (64 * WORDS) + longint'(i) * WORDS + (w % WORDS);
    return a[31:0];
  endfunction

  task automatic push_line(input int unsigned t, input int unsigned i,
                           input int unsigned foff);
    int unsigned s;
    exp_t e;
`ifdef CACHE_CWF_EN
    s = foff;
`else
    s = 0;
`endif
    for (int k = 0; k < WORDS; k++) begin
      e.addr = ref_addr(t, i, s + k);
      e.last = (k == WORDS - 1);
      exp_q.push_back(e);
    end
  endtask

  // Memory-side ack generator
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc_ctr++;
      case (ack_mode)
        0: bus.mem_ack = 1'b1;
        1: bus.mem_ack = (cyc_ctr % 3 == 0);
        2: bus.mem_ack = 1'($urandom_range(0, 1));
        default: bus.mem_ack = 1'b0;
      endcase
    end
  end

  // Monitor
  initial begin
    bit          exp_done;
    bit          prev_stall;
    logic [31:0] prev_addr;
    exp_t        e;
    exp_done   = 0;
    prev_stall = 0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        exp_done   = 0;
        prev_stall = 0;
        continue;
      end
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("busy_eq_req", 32'(bus.busy), 32'(bus.mem_req));
      if (exp_done)
        chk("req_in_done", 32'(bus.mem_req), 32'd0);
      exp_done = 0;
      if (prev_stall) begin
        chk("stall_req", 32'(bus.mem_req), 32'd1);
        chk("stall_addr", bus.mem_addr, prev_addr);
      end
      prev_stall = bus.mem_req && !bus.mem_ack;
      prev_addr  = bus.mem_addr;
      if (bus.mem_req && bus.mem_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_accept: addr 0x%08h with empty queue",
                   bus.mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("word_offset", 32'(bus.word_offset), {30'd0, e.addr[1:0]});
          exp_done = e.last;
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag_s);
    chk({tag_s, "_req"},  32'(bus.mem_req), 32'd0);
    chk({tag_s, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag_s, "_woff"}, 32'(bus.word_offset), 32'd0);
    chk({tag_s, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag_s, "_done"}, 32'(bus.done), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: busy %0b done %0b", bus.busy,
               bus.done);
    end
  endtask

  task automatic run_seq(input int unsigned t, input int unsigned i,
                         input int unsigned foff, input int mode,
                         input bit poke_mid, input bit poke_done);
    int cyc;
    wait_idle();
    ack_mode = mode;
    push_line(t, i, foff);
    bus.start        = 1'b1;
    bus.tag          = TAG_W'(t);
    bus.index        = IDX_W'(i);
    bus.first_offset = OFF_W'(foff);
    @(posedge clk);
    #2;
    bus.start        = 1'b0;
    bus.tag          = TAG_W'($urandom);
    bus.index        = IDX_W'($urandom);
    bus.first_offset = OFF_W'($urandom);
    cyc = 1;
    while (!bus.done && cyc < 300) begin
      @(posedge clk);
      #2;
      cyc++;
      bus.start = poke_mid && (cyc == 3);
      if (bus.start) begin
        bus.tag   = TAG_W'($urandom);
        bus.index = IDX_W'($urandom);
      end
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end else if (mode == 0) begin
      chk("line_cycles", 32'(cyc), 32'(WORDS + 1));
    end
    if (poke_done && bus.done) begin
      bus.start = 1'b1;
      bus.tag   = TAG_W'($urandom);
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      chk("start_in_done_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #2;
      chk("start_in_done_req", 32'(bus.mem_req), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.tag          = '0;
    bus.index        = '0;
    bus.first_offset = '0;
    ack_mode         = 3;
    repeat (2) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    run_seq(32'hABCDEF, 32'h15, 2, 0, 0, 0);
    run_seq(32'hABCDEF, 32'h15, 0, 1, 0, 0);
    run_seq(32'h000001, 32'h3F, 2, 0, 0, 0);
    run_seq(32'h000001, 32'h3F, 3, 1, 1, 0);
    run_seq(32'h123456, 32'h2A, 1, 0, 0, 1);

    // Abort after the second accepted word
    wait_idle();
    ack_mode = 0;
    push_line(32'h5A5A5A, 32'h0C, 1);
    bus.start        = 1'b1;
    bus.tag          = TAG_W'(32'h5A5A5A);
    bus.index        = IDX_W'(32'h0C);
    bus.first_offset = OFF_W'(1);
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #2;
    check_zero_outputs("abort");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_no_done", 32'(bus.done), 32'd0);
    run_seq(32'h5A5A5A, 32'h0C, 1, 0, 0, 0);

    for (int n = 0; n < 25; n++) begin
      run_seq($urandom_range(0, 32'hFFFFFF), $urandom_range(0, 63),
              $urandom_range(0, WORDS - 1), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
